// File: rtl/pipe_arb_ctrl.sv
// Two-port round-robin front end sharing a 3-stage F = (A+B) + (C-D) + D pipe, with run/drain/idle control.
// Define PIPE_ARB_STATS_EN to add per-port saturating transfer counters (stat_cnt0/1) and a stat_clr input.
module pipe_arb_ctrl #(
    parameter int W       = 10,
    parameter int MAX_OUT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [W-1:0] req_a0,
    input  logic [W-1:0] req_b0,
    input  logic [W-1:0] req_c0,
    input  logic [W-1:0] req_d0,
    input  logic [W-1:0] req_a1,
    input  logic [W-1:0] req_b1,
    input  logic [W-1:0] req_c1,
    input  logic [W-1:0] req_d1,
    output logic [1:0]   rsp_valid,
    output logic [W-1:0] rsp_data,
    output logic         idle
`ifdef PIPE_ARB_STATS_EN
    ,
    input  logic         stat_clr,
    output logic [15:0]  stat_cnt0,
    output logic [15:0]  stat_cnt1
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] MAX_CNT  = 2'(MAX_OUT);

    logic [1:0]   state_q, state_d;
    logic         rr_q, rr_d;
    logic [1:0]   elig;
    logic [1:0]   grant;
    logic         xfer;
    logic         gport;

    logic [W-1:0] op_a [2];
    logic [W-1:0] op_b [2];
    logic [W-1:0] op_c [2];
    logic [W-1:0] op_d [2];

    logic         s1_valid_q, s1_valid_d, s1_tag_q, s1_tag_d;
    logic [W-1:0] s1_x1_q, s1_x1_d, s1_x2_q, s1_x2_d, s1_dd_q, s1_dd_d;
    logic         s2_valid_q, s2_valid_d, s2_tag_q, s2_tag_d;
    logic [W-1:0] s2_x3_q, s2_x3_d, s2_dd_q, s2_dd_d;
    logic         s3_valid_q, s3_valid_d, s3_tag_q, s3_tag_d;
    logic [W-1:0] s3_f_q, s3_f_d;
    logic [1:0]   rsp_valid_q, rsp_valid_d;
    logic [W-1:0] rsp_data_q, rsp_data_d;

    assign op_a[0] = req_a0;
    assign op_b[0] = req_b0;
    assign op_c[0] = req_c0;
    assign op_d[0] = req_d0;
    assign op_a[1] = req_a1;
    assign op_b[1] = req_b1;
    assign op_c[1] = req_c1;
    assign op_d[1] = req_d1;

    // Per-port outstanding counter and eligibility.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic [1:0] cnt_q, cnt_d;

            assign elig[gi] = (state_q == ST_RUN) && req_valid[gi] && (cnt_q < MAX_CNT);

            always_comb begin
                cnt_d = cnt_q;
                if (grant[gi] && !rsp_valid_q[gi]) begin
                    cnt_d = cnt_q + 2'd1;
                end else if (!grant[gi] && rsp_valid_q[gi]) begin
                    cnt_d = cnt_q - 2'd1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= 2'd0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    // rr_q names the port that wins when both are eligible.
    always_comb begin
        grant = elig;
        if (elig == 2'b11) begin
            grant = rr_q ? 2'b10 : 2'b01;
        end
    end

    assign req_ready = grant;
    assign xfer      = |grant;
    assign gport     = grant[1];

    always_comb begin
        rr_d = rr_q;
        if (xfer) begin
            rr_d = ~gport;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (en) state_d = ST_RUN;
            ST_RUN:   if (!en) state_d = ST_DRAIN;
            ST_DRAIN: if (!(s1_valid_q || s2_valid_q || s3_valid_q)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s1_valid_d = xfer;
        s1_tag_d   = gport;
        s1_x1_d    = op_a[gport] + op_b[gport];
        s1_x2_d    = op_c[gport] - op_d[gport];
        s1_dd_d    = op_d[gport];

        s2_valid_d = s1_valid_q;
        s2_tag_d   = s1_tag_q;
        s2_x3_d    = s1_x1_q + s1_x2_q;
        s2_dd_d    = s1_dd_q;

        s3_valid_d = s2_valid_q;
        s3_tag_d   = s2_tag_q;
        s3_f_d     = s2_x3_q + s2_dd_q;

        rsp_valid_d = 2'b00;
        rsp_data_d  = rsp_data_q;
        if (s3_valid_q) begin
            rsp_valid_d = s3_tag_q ? 2'b10 : 2'b01;
            rsp_data_d  = s3_f_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_q        <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_tag_q    <= 1'b0;
            s1_x1_q     <= '0;
            s1_x2_q     <= '0;
            s1_dd_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_tag_q    <= 1'b0;
            s2_x3_q     <= '0;
            s2_dd_q     <= '0;
            s3_valid_q  <= 1'b0;
            s3_tag_q    <= 1'b0;
            s3_f_q      <= '0;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            s1_valid_q  <= s1_valid_d;
            s1_tag_q    <= s1_tag_d;
            s1_x1_q     <= s1_x1_d;
            s1_x2_q     <= s1_x2_d;
            s1_dd_q     <= s1_dd_d;
            s2_valid_q  <= s2_valid_d;
            s2_tag_q    <= s2_tag_d;
            s2_x3_q     <= s2_x3_d;
            s2_dd_q     <= s2_dd_d;
            s3_valid_q  <= s3_valid_d;
            s3_tag_q    <= s3_tag_d;
            s3_f_q      <= s3_f_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign idle      = (state_q == ST_IDLE);

`ifdef PIPE_ARB_STATS_EN
    // Clear takes priority over a same-cycle increment; counts stick at all-ones.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stat
            logic [15:0] stat_q, stat_d;

            always_comb begin
                stat_d = stat_q;
                if (stat_clr) begin
                    stat_d = 16'h0000;
                end else if (grant[gi] && (stat_q != 16'hFFFF)) begin
                    stat_d = stat_q + 16'h0001;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stat_q <= 16'h0000;
                end else begin
                    stat_q <= stat_d;
                end
            end
        end
    endgenerate

    assign stat_cnt0 = g_stat[0].stat_q;
    assign stat_cnt1 = g_stat[1].stat_q;
`endif

endmodule

// File: tb/tb_pipe_arb_ctrl.sv
// Scoreboard bench for pipe_arb_ctrl: expected results are queued on each handshake and matched on rsp_valid.
`timescale 1ns/1ps
module tb_pipe_arb_ctrl;

    localparam int W       = 10;
    localparam int MAX_OUT = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   req_ready;
    logic [W-1:0] a0, b0, c0, d0, a1, b1, c1, d1;
    logic [1:0]   rsp_valid;
    logic [W-1:0] rsp_data;
    logic         idle;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [1:0]   port;
        logic [W-1:0] data;
        int           due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    pipe_arb_ctrl #(.W(W), .MAX_OUT(MAX_OUT)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (a0),
        .req_b0    (b0),
        .req_c0    (c0),
        .req_d0    (d0),
        .req_a1    (a1),
        .req_b1    (b1),
        .req_c1    (c1),
        .req_d1    (d1),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Exact integer arithmetic, reduced mod 2^W at the end.
    function automatic logic [W-1:0] model_f(input logic [W-1:0] a, b, c, d);
        int s;
        s = (int'(a) + int'(b)) + (int'(c) - int'(d)) + int'(d);
        return s[W-1:0];
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                $display("rsp cycle %0d: valid=%b data=%0d (want %b/%0d)", cyc, rsp_valid, rsp_data, mon_e.port, mon_e.data);
                check_val("rsp_valid", rsp_valid, mon_e.port);
                check_val("rsp_data", rsp_data, mon_e.data);
            end else if (rsp_valid != 2'b00) begin
                check_val("rsp_spurious", rsp_valid, 2'b00);
            end
            if (req_ready != 2'b00) begin
                check_val("ready_onehot", $countones(req_ready), 1);
                check_val("ready_wo_valid", req_ready & ~req_valid, 2'b00);
            end
            if (req_valid[0] && req_ready[0]) sb.push_back('{2'b01, model_f(a0, b0, c0, d0), cyc + 4});
            if (req_valid[1] && req_ready[1]) sb.push_back('{2'b10, model_f(a1, b1, c1, d1), cyc + 4});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int p, input logic [W-1:0] a, b, c, d);
        if (p == 0) begin
            a0 = a; b0 = b; c0 = c; d0 = d;
        end else begin
            a1 = a; b1 = b; c1 = c; d1 = d;
        end
    endtask

    task automatic rand_ops(input int p);
        set_ops(p, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    endtask

    task automatic send(input int p, input logic [W-1:0] a, b, c, d);
        logic got;
        got = 1'b0;
        set_ops(p, a, b, c, d);
        req_valid[p] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready[p]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check_val("send_timeout", req_ready[p], 1);
        tick();
        req_valid[p] = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) check_val("pending_rsp", sb.size(), 0);
        tick();
    endtask

    // Port 0 alone streams: MAX_OUT accepts, then ready low until the first response retires.
    task automatic stream0(input string tag);
        logic [1:0] g;
        rand_ops(0);
        req_valid = 2'b01;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            g = req_ready;
            check_val(tag, g[0], (k < MAX_OUT || k >= 5) ? 1 : 0);
            tick();
            if (g[0]) rand_ops(0);
        end
        req_valid = 2'b00;
    endtask

    initial begin
        logic [1:0] g;
        logic [1:0] exp_g;
        int c2;

        set_ops(0, '0, '0, '0, '0);
        set_ops(1, '0, '0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_idle", idle, 1);
        check_val("rst_ready", req_ready, 2'b00);
        check_val("rst_rsp_valid", rsp_valid, 2'b00);
        check_val("rst_rsp_data", rsp_data, 0);
        tick();
        rst_n = 1'b1;
        en    = 1'b1;
        @(negedge clk);
        check_val("idle_pre_run", idle, 1);
        @(negedge clk);
        check_val("run_idle", idle, 0);
        tick();

        send(0, 10'd1, 10'd2, 10'd10, 10'd4);
        wait_empty();
        check_val("basic_hold", rsp_data, 13);

        send(1, 10'd1000, 10'd100, 10'd0, 10'd0);
        send(1, 10'd0, 10'd0, 10'd0, 10'd5);
        wait_empty();

        rand_ops(0);
        rand_ops(1);
        req_valid = 2'b11;
        exp_g = 2'b01;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            g = req_ready;
            check_val("fair_grant", g, exp_g);
            tick();
            if (g[0]) rand_ops(0);
            if (g[1]) rand_ops(1);
            exp_g = {exp_g[0], exp_g[1]};
        end
        req_valid = 2'b00;
        wait_empty();

        stream0("throttle_ready");
        wait_empty();

        rand_ops(0);
        req_valid = 2'b01;
        @(negedge clk);
        check_val("drain_g0", req_ready, 2'b01);
        tick();
        rand_ops(1);
        req_valid = 2'b10;
        en = 1'b0;
        @(negedge clk);
        check_val("drain_g1", req_ready, 2'b10);
        c2 = cyc;
        tick();
        rand_ops(0);
        rand_ops(1);
        req_valid = 2'b11;
        en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (idle) break;
            check_val("drain_noready", req_ready, 2'b00);
        end
        check_val("drain_idle_cyc", cyc, c2 + 5);
        @(negedge clk);
        check_val("rerun_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        wait_empty();

        rand_ops(0);
        req_valid = 2'b01;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("pre_rst_ready", req_ready[0], 1);
            tick();
            rand_ops(0);
        end
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        check_val("midrst_idle", idle, 1);
        check_val("midrst_ready", req_ready, 2'b00);
        check_val("midrst_rsp", rsp_valid, 2'b00);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val("midrst_rsp_hold", rsp_valid, 2'b00);
        end
        tick();
        rst_n = 1'b1;
        tick();
        stream0("post_rst_ready");
        wait_empty();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_arb_ctrl.md
Name: pipe_arb_ctrl

Overview:
- Shares one 3-stage pipelined arithmetic unit, F = (A+B) + (C-D) + D computed mod 2^W, between two requesters.
- Round-robin arbitration issues at most one operation per cycle into the pipe.
- Tracks which port owns each pipe slot and returns the result to that port.
- Limits in-flight operations per port, and gives a run/drain/idle control so software can quiesce the unit.

Parameters:
- W, 10, operand/result width.
- MAX_OUT, 2, max in-flight ops per port (1..3).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; low requests drain.
- req_valid  in  2  per-port request valid (bit i = port i).
- req_ready  out  2  per-port grant; transfer when valid&ready.
- req_a0, req_b0, req_c0, req_d0  in  W each  port 0 operands.
- req_a1, req_b1, req_c1, req_d1  in  W each  port 1 operands.
- rsp_valid  out  2  one-cycle result strobe per port.
- rsp_data  out  W  result; valid when any rsp_valid bit is high.
- idle  out  1  high in IDLE state.

Behaviour:
Reset (async assert):
- State = IDLE; rr pointer = port 0 preferred.
- Pipe valid bits and tags = 0; outstanding counters = 0.
- rsp_valid = 0, rsp_data = 0, idle = 1, req_ready = 0.

FSM (IDLE, RUN, DRAIN):
- IDLE: en=1 -> RUN next edge.
- RUN: en=0 -> DRAIN next edge.
- DRAIN: all three pipe valid bits 0 -> IDLE. en re-asserted during DRAIN is ignored until IDLE is reached.

Eligibility and arbitration:
- Port i is eligible when state==RUN, req_valid[i]=1 and out_cnt[i] < MAX_OUT.
- req_ready is combinational from req_valid, state and counters. Requesters must not make valid depend on ready.
- Only one bit of req_ready may be high per cycle.
- If both ports are eligible, grant the port not granted most recently. Otherwise grant the single eligible port.
- The rr pointer updates only on an actual transfer.
- A requester holds operands stable while valid is high and ready is low.

Pipeline (1 op/cycle, no stalls, latency 3):
- S1 captures X1=A+B, X2=C-D, D, tag and valid from the granted port at edge N.
- S2: X3=X1+X2, plus D, tag, valid.
- S3: F=X3+D, registered.
- rsp_data = F, and rsp_valid[tag] = 1, during the cycle after edge N+3.
- All sums and differences are truncated to W bits, two's-complement wrap.
- rsp_valid is 0 when S3 is not valid. rsp_data holds its last value when no response is issued.

Outstanding counters:
- out_cnt[i] +1 on transfer from port i; -1 when rsp_valid[i] fires.
- Transfer and response on the same port in the same cycle: counter unchanged.
- Saturation is unreachable by construction.

Boundaries:
- Pipe full with both ports at MAX_OUT: req_ready = 0 until a response retires.
- en dropped in the same cycle as a transfer: that transfer completes and its response is delivered during DRAIN.
- Reset mid-operation: in-flight ops are discarded with no rsp_valid, and counters clear.

Optional Feature:
- Macro: PIPE_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_cnt0 and stat_cnt1, 16 bits each, counting transfers per port.
  - Counters saturate at 16'hFFFF and reset to 0 on rst_n.
  - Also adds input stat_clr, a synchronous clear that wins over a simultaneous increment.
- Undefined: these ports and registers do not exist. Core behaviour is identical.

Test Plan:
- Basic op: reset, en=1, port 0 sends A=1,B=2,C=10,D=4 at edge N -> rsp_valid=2'b01, rsp_data=13 in the cycle after edge N+3. idle=0.
- Wrap: port 1 sends A=1000,B=100,C=0,D=0 -> rsp_data=76, rsp_valid=2'b10. Port 1 sends A=0,B=0,C=0,D=5 -> rsp_data=0 (X2=1019 intermediate).
- Fairness: both ports hold valid continuously with MAX_OUT=3 -> grants alternate 0,1,0,1. Responses arrive in issue order with correct rsp_valid bit and no bubbles.
- Throttle: MAX_OUT=2, only port 0 valid continuously -> transfers at edges N and N+1, ready low at N+2. Ready re-asserts in the cycle after the first response retires.
- Drain: 2 ops in flight, en dropped -> no new req_ready. Both responses delivered, then idle=1 one cycle after the pipe empties. en=1 -> RUN again.
- Reset mid-flight: rst_n low with 3 ops in flight -> rsp_valid stays 0, idle=1 immediately. After release, counters are 0 and a new op returns the correct result.
